// File: rtl/clk_div_pkg.sv
// Shared constants for the programmable clock divider: default register width
// and the divisor loaded at reset.
package clk_div_pkg;

  localparam int          DIV_WIDTH_DEFAULT = 32;
  localparam int unsigned DIV_DEFAULT       = 5000;

endpackage

// File: rtl/clk_div_if.sv
// Control and status bundle of clk_div_prog; clk_in and rst stay plain ports.
// div_load is a single-cycle strobe with no ready: every cycle it is high the
// divider captures div_val, and the host never waits.
interface clk_div_if
  import clk_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
);

  logic             en;
  logic             sync_clr;
  logic             div_load;
  logic [WIDTH-1:0] div_val;
  logic             clk_out;
  logic             tick_out;
  logic [WIDTH-1:0] div_active;
  logic             div_pending;
  logic [WIDTH-1:0] count;

  modport master (
    output en, sync_clr, div_load, div_val,
    input  clk_out, tick_out, div_active, div_pending, count
  );

  modport slave (
    input  en, sync_clr, div_load, div_val,
    output clk_out, tick_out, div_active, div_pending, count
  );

endinterface

// File: rtl/clk_div_core.sv
// Phase counter of the divider: counts enabled cycles from 0 up to limit and
// flags the terminal cycle combinationally.
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             term
);

  assign term = en && (count == limit);

  // limit only changes at count==0 or on restart, so count never passes it
  always_ff @(posedge clk_in) begin
    if (rst || clr) begin
      count <= '0;
    end else if (term) begin
      count <= '0;
    end else if (en) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable divider: 50% duty divided clock plus one-cycle tick,
// with a shadowed divisor that takes effect at the next period boundary.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int          WIDTH       = DIV_WIDTH_DEFAULT,
  parameter int unsigned DEFAULT_DIV = DIV_DEFAULT
) (
  input  logic      clk_in,
  input  logic      rst,
  clk_div_if.slave  bus
);

  logic [WIDTH-1:0] count;
  logic             term;
  logic             clk_q;
  logic             tick_q;
  logic [WIDTH-1:0] active_q;
  logic [WIDTH-1:0] shadow_q;
  logic             pending_q;

  clk_div_core #(.WIDTH(WIDTH)) u_core (
    .clk_in (clk_in),
    .rst    (rst),
    .clr    (bus.sync_clr),
    .en     (bus.en),
    .limit  (active_q),
    .count  (count),
    .term   (term)
  );

  always_ff @(posedge clk_in) begin
    if (rst) begin
      clk_q     <= 1'b0;
      tick_q    <= 1'b0;
      active_q  <= WIDTH'(DEFAULT_DIV);
      shadow_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      if (bus.sync_clr) begin
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        tick_q <= term;
        if (term) clk_q <= ~clk_q;
      end
      if ((bus.sync_clr || term) && pending_q) begin
        active_q  <= shadow_q;
        pending_q <= 1'b0;
      end
      // Ordered after the apply so a load on a boundary stays pending
      if (bus.div_load) begin
        shadow_q  <= bus.div_val;
        pending_q <= 1'b1;
      end
    end
  end

  assign bus.clk_out     = clk_q;
  assign bus.tick_out    = tick_q;
  assign bus.div_active  = active_q;
  assign bus.div_pending = pending_q;
  assign bus.count       = count;

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog (WIDTH=8, DEFAULT_DIV=3): directed scenarios with
// literal expectations, then random traffic checked every cycle against a model.
module tb_clk_div_prog;

  localparam int W   = 8;
  localparam int DEF = 3;

  logic clk_in;
  logic rst;

  clk_div_if #(.WIDTH(W)) bus ();

  clk_div_prog #(.WIDTH(W), .DEFAULT_DIV(DEF)) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  bit checking    = 0;

  // Clock/reset
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Reference model: phase as enabled cycles since the last boundary, the
  // divided clock as the parity of boundaries since restart.
  longint pos;
  longint nbound;
  bit     m_tick;
  longint m_active;
  longint m_shadow;
  bit     m_pending;
  bit     m_boundary;

  always @(posedge clk_in) begin
    if (rst) begin
      pos = 0; nbound = 0; m_tick = 0;
      m_active = DEF; m_shadow = 0; m_pending = 0;
    end else begin
      m_boundary = 0;
      if (bus.sync_clr) begin
        pos = 0; nbound = 0; m_tick = 0;
      end else if (bus.en) begin
        pos = pos + 1;
        m_boundary = (pos == m_active + 1);
        if (m_boundary) begin
          pos = 0;
          nbound = nbound + 1;
        end
        m_tick = m_boundary;
      end else begin
        m_tick = 0;
      end
      if ((bus.sync_clr || m_boundary) && m_pending) begin
        m_active  = m_shadow;
        m_pending = 0;
      end
      if (bus.div_load) begin
        m_shadow  = longint'(bus.div_val);
        m_pending = 1;
      end
    end
  end

  // Scoreboard compare, every cycle on the falling edge
  always @(negedge clk_in) begin
    if (checking) begin
      vectors++;
      if (bus.clk_out !== nbound[0]) begin
        miscompares++;
        $display("FAIL clk_out t=%0t got %b want %b", $time, bus.clk_out, nbound[0]);
      end
      if (bus.tick_out !== m_tick) begin
        miscompares++;
        $display("FAIL tick_out t=%0t got %b want %b", $time, bus.tick_out, m_tick);
      end
      if (bus.div_pending !== m_pending) begin
        miscompares++;
        $display("FAIL div_pending t=%0t got %b want %b", $time, bus.div_pending, m_pending);
      end
      if ($isunknown(bus.div_active) || longint'(bus.div_active) != m_active) begin
        miscompares++;
        $display("FAIL div_active t=%0t got %0d want %0d", $time, bus.div_active, m_active);
      end
      if ($isunknown(bus.count) || longint'(bus.count) != pos) begin
        miscompares++;
        $display("FAIL count t=%0t got %0d want %0d", $time, bus.count, pos);
      end
    end
  end

  // Driver tasks
  task automatic cycle();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1; bus.en = 0; bus.sync_clr = 0; bus.div_load = 0; bus.div_val = '0;
    cycle();
    cycle();
    rst = 0; bus.en = 1;
  endtask

  task automatic load(input logic [W-1:0] v);
    bus.div_load = 1; bus.div_val = v;
    cycle();
    bus.div_load = 0;
  endtask

  task automatic wait_tick(input int budget, output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!bus.tick_out && n < budget);
    if (!bus.tick_out) begin
      miscompares++;
      $display("FAIL wait_tick timeout after %0d cycles", n);
    end
  endtask

  task automatic wait_count(input int target);
    int k = 0;
    while (int'(bus.count) != target && k < 600) begin
      cycle();
      k++;
    end
    check("wait_count", longint'(bus.count), longint'(target));
  endtask

  int          n;
  logic [31:0] mask;
  bit          exp_clk;

  initial begin
    rst = 1; bus.en = 0; bus.sync_clr = 0; bus.div_load = 0; bus.div_val = '0;
    cycle();
    checking = 1;

    // Reset state and free-running D=3
    do_reset();
    check("rst_count", longint'(bus.count), 0);
    check("rst_clk", longint'(bus.clk_out), 0);
    check("rst_active", longint'(bus.div_active), 3);
    mask = '0;
    for (int i = 1; i <= 20; i++) begin
      cycle();
      if (bus.tick_out) mask[i] = 1'b1;
      if (i == 4)  check("clk_after_4", longint'(bus.clk_out), 1);
      if (i == 8)  check("clk_after_8", longint'(bus.clk_out), 0);
    end
    check("tick_mask", longint'(mask), longint'(32'h0011_1110));
    check("clk_after_20", longint'(bus.clk_out), 1);

    // Load 1 mid-period: applied at the next boundary only
    cycle();
    load(8'd1);
    check("ld1_active_hold", longint'(bus.div_active), 3);
    check("ld1_pending", longint'(bus.div_pending), 1);
    wait_tick(20, n);
    check("ld1_first_gap", n, 2);
    check("ld1_active_new", longint'(bus.div_active), 1);
    check("ld1_pending_clr", longint'(bus.div_pending), 0);
    wait_tick(20, n);
    check("d1_gap_a", n, 2);
    wait_tick(20, n);
    check("d1_gap_b", n, 2);

    // Load 5 on the terminal edge while 1 is pending
    do_reset();
    load(8'd1);
    wait_count(3);
    load(8'd5);
    check("ld5_tick", longint'(bus.tick_out), 1);
    check("ld5_active", longint'(bus.div_active), 1);
    check("ld5_pending", longint'(bus.div_pending), 1);
    wait_tick(20, n);
    check("ld5_gap1", n, 2);
    check("ld5_active_new", longint'(bus.div_active), 5);
    check("ld5_pending_clr", longint'(bus.div_pending), 0);
    wait_tick(20, n);
    check("ld5_gap2", n, 6);

    // Enable low mid-period freezes the phase
    do_reset();
    wait_count(2);
    bus.en = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("freeze_count", longint'(bus.count), 2);
      check("freeze_tick", longint'(bus.tick_out), 0);
      check("freeze_clk", longint'(bus.clk_out), 0);
    end
    bus.en = 1;
    wait_tick(20, n);
    check("resume_gap", n, 2);

    // D=0 via restart: tick constant, clk_out toggles every cycle
    load(8'd0);
    bus.sync_clr = 1;
    cycle();
    bus.sync_clr = 0;
    check("d0_active", longint'(bus.div_active), 0);
    check("d0_clk", longint'(bus.clk_out), 0);
    check("d0_pending", longint'(bus.div_pending), 0);
    exp_clk = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      exp_clk = ~exp_clk;
      check("d0_tick", longint'(bus.tick_out), 1);
      check("d0_clk_run", longint'(bus.clk_out), longint'(exp_clk));
    end

    // Reset with a pending divisor discards it
    do_reset();
    load(8'd7);
    cycle();
    check("pre_rst_count", longint'(bus.count), 2);
    check("pre_rst_pending", longint'(bus.div_pending), 1);
    rst = 1;
    cycle();
    check("post_rst_count", longint'(bus.count), 0);
    check("post_rst_active", longint'(bus.div_active), 3);
    check("post_rst_pending", longint'(bus.div_pending), 0);
    rst = 0;
    wait_tick(20, n);
    check("post_rst_gap1", n, 4);
    wait_tick(20, n);
    check("post_rst_gap2", n, 4);

    // Largest divisor, applied by restart
    load(8'd255);
    bus.sync_clr = 1;
    cycle();
    bus.sync_clr = 0;
    check("dmax_active", longint'(bus.div_active), 255);
    wait_tick(300, n);
    check("dmax_gap1", n, 256);
    wait_tick(300, n);
    check("dmax_gap2", n, 256);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 499) == 0);
      bus.en       = ($urandom_range(0, 9) < 8);
      bus.sync_clr = ($urandom_range(0, 99) == 0);
      bus.div_load = ($urandom_range(0, 19) == 0);
      bus.div_val  = W'($urandom_range(0, 9));
      cycle();
    end
    rst = 0; bus.sync_clr = 0; bus.div_load = 0;
    cycle();

    checking = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
